// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: load/trigger link between the sequencer and a countdown timer.
//   value   : interval to load into the timer (meaningful only while valid=1)
//   valid   : one-cycle load strobe
//   enable  : timer count enable
//   trigger : timer expiry indication, driven by the timer
// Modports: master = sequencer side, slave = timer side.
interface timer_sequencer_if #(
  parameter int W = 5
);
  logic [W-1:0] value;
  logic         valid;
  logic         enable;
  logic         trigger;

  modport master (
    output value,
    output valid,
    output enable,
    input  trigger
  );

  modport slave (
    input  value,
    input  valid,
    input  enable,
    output trigger
  );
endinterface

// File: rtl/timer_sequencer.sv
// timer_sequencer: plays a small schedule of intervals into a countdown timer.
// Each non-zero entry is loaded (one-cycle valid), the timer is enabled, and the
// rising edge of trigger advances to the next entry. Zero entries are skipped.
// At the end of the schedule the sequence either restarts (loop=1) or finishes.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    : append an interval to the schedule (IDLE only, not full)
//   clear             : empty the schedule (IDLE only, wins over wr_en)
//   start, stop       : begin at entry 0 / abort the running sequence
//   loop              : sampled after the last entry, 1 = restart at entry 0
//   tmr               : timer load/enable/trigger link (master side)
//   busy              : state is not IDLE
//   step, entries     : current entry index, number of stored entries
//   step_done         : one-cycle pulse when an entry expires
//   seq_done          : one-cycle pulse when the sequence completes
// All outputs are registered: each output register is loaded from the
// next-state decode, so outputs line up with the state they describe.
module timer_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [W-1:0]              wr_data,
  input  logic                      clear,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  timer_sequencer_if.master         tmr,
  output logic                      busy,
  output logic [$clog2(DEPTH)-1:0]  step,
  output logic [$clog2(DEPTH):0]    entries,
  output logic                      step_done,
  output logic                      seq_done
);

  localparam int SW = $clog2(DEPTH);
  localparam int EW = SW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  step_q, step_d;
  logic [EW-1:0]  entries_q, entries_d;
  logic           trig_dly_q;
  logic [W-1:0]   sched_q [DEPTH];

  logic [W-1:0]   value_q, value_d;
  logic           valid_q, valid_d;
  logic           enable_q, enable_d;
  logic           busy_q, busy_d;
  logic           step_done_q, step_done_d;
  logic           seq_done_q, seq_done_d;

  logic           wr_fire;
  logic           trig_edge;
  logic           last_entry;

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    entries_d   = entries_q;
    step_done_d = 1'b0;
    seq_done_d  = 1'b0;
    wr_fire     = 1'b0;

    trig_edge  = tmr.trigger & ~trig_dly_q;
    // step is the last stored entry when step+1 reaches the entry count
    last_entry = ({1'b0, step_q} + EW'(1)) >= entries_q;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          entries_d = '0;
        end else if (wr_en && (entries_q < EW'(DEPTH))) begin
          wr_fire   = 1'b1;
          entries_d = entries_q + EW'(1);
        end
        if (start) begin
          if (entries_q != '0) begin
            state_d = S_LOAD;
            step_d  = '0;
          end else begin
            // nothing to play: report completion straight away
            seq_done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // a zero interval is skipped without loading the timer
        state_d = (sched_q[step_q] == '0) ? S_NEXT : S_RUN;
      end
      S_RUN: begin
        if (trig_edge) begin
          step_done_d = 1'b1;
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!last_entry) begin
          step_d  = step_q + SW'(1);
          state_d = S_LOAD;
        end else if (loop) begin
          step_d  = '0;
          state_d = S_LOAD;
        end else begin
          seq_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort overrides any advance or completion decided above
    if (stop && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      step_d      = step_q;
      step_done_d = 1'b0;
      seq_done_d  = 1'b0;
    end

    valid_d  = (state_d == S_LOAD) && (sched_q[step_d] != '0);
    enable_d = (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    value_d  = sched_q[step_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      entries_q   <= '0;
      trig_dly_q  <= 1'b0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      entries_q   <= entries_d;
      trig_dly_q  <= tmr.trigger;
      value_q     <= value_d;
      valid_q     <= valid_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      seq_done_q  <= seq_done_d;
    end
  end

  // Schedule storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      sched_q[entries_q[SW-1:0]] <= wr_data;
    end
  end

  assign tmr.value  = value_q;
  assign tmr.valid  = valid_q;
  assign tmr.enable = enable_q;
  assign busy       = busy_q;
  assign step       = step_q;
  assign entries    = entries_q;
  assign step_done  = step_done_q;
  assign seq_done   = seq_done_q;

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Programs the countdown timer from a small schedule of intervals. The block drives the timer's `value`/`valid` load port and `enable`, then consumes its `trigger` to advance to the next interval, optionally looping. It sits between the control/config logic and the timer, at the other end of the timer's load/trigger interface.

## Interface
- `DEPTH`, default 4: number of schedule entries (power of two, ≥2).
- `W`, default 5: interval width; matches the timer `value` width.

- `clk`: input, 1 bit, rising-edge clock.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `wr_en`: input, 1 bit. Append `wr_data` to the schedule.
- `wr_data`: input, `W` bits. Interval to append.
- `clear`: input, 1 bit. Empty the schedule.
- `start`: input, 1 bit. Begin the sequence at entry 0.
- `stop`: input, 1 bit. Abort the sequence.
- `loop`: input, 1 bit. Sampled at the end of the last entry; 1 means restart at entry 0.
- `trigger`: input, 1 bit. Timer expiry indication; only its rising edge is used.
- `value`: output, `W` bits. Load value to the timer.
- `valid`: output, 1 bit. Load strobe to the timer.
- `enable`: output, 1 bit. Timer count enable.
- `busy`: output, 1 bit. High in any state other than IDLE.
- `step`: output, log2(`DEPTH`) bits. Index of the current entry.
- `entries`: output, log2(`DEPTH`)+1 bits. Number of stored entries.
- `step_done`: output, 1 bit. One-cycle pulse when an entry expires.
- `seq_done`: output, 1 bit. One-cycle pulse when the sequence completes.

## Operation
- Schedule storage: `DEPTH` × `W` register array plus an `entries` counter.
  - `wr_en` in IDLE with `entries < DEPTH`: store at index `entries`, then increment.
  - Writes are ignored when the schedule is full or `busy` is high.
  - `clear` in IDLE sets `entries` to 0; `clear` has priority over `wr_en` in the same cycle.
  - `clear` while busy is ignored.
- Trigger edge detect: `trig_d` is registered every cycle. An edge is `trigger & ~trig_d`.
- State machine states: IDLE, LOAD, RUN, NEXT.
  - IDLE, on `start` with `entries > 0`: go to LOAD and set `step` to 0.
  - IDLE, on `start` with `entries == 0`: pulse `seq_done` next cycle and stay in IDLE.
  - LOAD, entry nonzero: drive `valid`=1 and `value=sched[step]` for exactly one cycle with `enable`=0, then go to RUN.
  - LOAD, entry == 0: go directly to NEXT without asserting `valid`. Zero intervals are skipped and produce no `step_done`.
  - RUN: drive `enable`=1 and `valid`=0. On a trigger edge, pulse `step_done` and go to NEXT.
  - NEXT (`enable`=0):
    - If `step` < `entries`−1: increment `step` and go to LOAD.
    - Otherwise, with `loop`=1: set `step` to 0 and go to LOAD.
    - Otherwise, with `loop`=0: pulse `seq_done` and go to IDLE.
- `stop` in LOAD, RUN or NEXT: go to IDLE next cycle and drop `enable`/`valid`. No `step_done` or `seq_done` pulse; `step` is held.
- `stop` has priority over a trigger edge and over `start` in the same cycle.
- `start` while busy is ignored.
- Output decode: `value` shows `sched[step]` in every state. It is only meaningful while `valid`=1.

## Timing
- All outputs are registered.
- `reset` sets state=IDLE, `step`=0, `entries`=0, `trig_d`=0, and all outputs to 0, including `value`.
- Schedule contents are not reset.
- `start` sampled at cycle t:
  - `valid`=1 at t+1.
  - `enable`=1 from t+2.
- A trigger edge sampled at cycle u in RUN:
  - `step_done` at u+1, with NEXT in effect.
  - The next entry's `valid` at u+2.
- Turnaround: 2 cycles with `enable`=0 between entries (NEXT + LOAD).
- `seq_done` fires in the cycle after NEXT; `busy` is 0 in that same cycle.
- A trigger edge outside RUN is ignored, but `trig_d` still tracks it.
- A `trigger` held high on RUN entry does not advance the sequence until it falls and rises again.
- `reset` mid-sequence takes effect next edge, identical to power-up. No pulses are emitted.

## Test plan
- Reset: assert `reset` for 2 cycles with `trigger`=1. Required: all outputs 0, `entries`=0, no `step_done` once `reset` is released.
- Single step: write 5, pulse `start`, then raise `trigger` 6 cycles after `enable` rises.
  - `valid`=1 with `value`=5 for one cycle.
  - `enable`=1 until the edge.
  - `step_done` then `seq_done`, then `busy`=0.
- Three entries with loop: write 3, 0, 7 with `loop`=1.
  - Loads are 3 then 7; the 0 is skipped with no `step_done`.
  - After 7 expires, `step` returns to 0 and 3 is reloaded.
  - With `loop`=0 at the end of the 2nd pass, `seq_done` fires.
- Full/ignored writes: write 5 values with `DEPTH`=4. Required: `entries`=4 and `sched[3]` = 4th value. `wr_en` and `clear` while busy leave `entries` unchanged.
- Stop mid-RUN: `stop` and a trigger edge in the same cycle.
  - IDLE next cycle, `enable`=0.
  - No `step_done` or `seq_done`.
  - `start` afterwards reloads entry 0.
- Empty start and held trigger:
  - `start` with `entries`=0 gives a `seq_done` pulse at t+1 and `busy` never 1.
  - `trigger` held high into RUN: no advance until a 0→1 transition.
